hwpf_req_queue: RTL and testbench
=================================

HWPF_REQ_QUEUE -- requirements
Module: hwpf_req_queue

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 64, cache line size in bytes (power of two).
REQ-002 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >=2).
REQ-003 SHALL have parameter INSERTS, default 2, number of insert ports and of demand-snoop ports.
REQ-004 SHALL have parameter ADDR_W, default 40, byte address width.
REQ-005 SHALL have parameter TID_W, default 7, transaction id width.
REQ-006 SHALL have port clk_i  in  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports flush_i  in  1  clear queue; and lock_i  in  1  freeze queue.
REQ-009 SHALL have ports ins_valid_i  in  INSERTS  prefetch candidates; ins_addr_i  in  INSERTS x ADDR_W; ins_tid_i  in  INSERTS x TID_W.
REQ-010 SHALL have ports ins_accept_o  out  INSERTS  candidate enqueued; and drop_o  out  1  pulse, at least one valid candidate not enqueued for lack of space.
REQ-011 SHALL have ports dmd_valid_i  in  INSERTS  CPU demand issued; dmd_addr_i  in  INSERTS x ADDR_W; dmd_hit_o  out  INSERTS  demand matched a queued line.
REQ-012 SHALL have ports req_valid_o  out  1; req_ready_i  in  1; req_addr_o  out  ADDR_W  line-aligned; req_tid_o  out  TID_W.
REQ-013 SHALL have port occupancy_o  out  $clog2(DEPTH)+1  valid entry count.

Function
REQ-014 Line address SHALL be addr[ADDR_W-1:$clog2(LINE_BYTES)]; req_addr_o SHALL carry low $clog2(LINE_BYTES) bits zero.
REQ-015 Queue SHALL be age-ordered; entry 0 is oldest; req_valid_o/req_addr_o/req_tid_o SHALL be driven from entry 0 registers, no combinational path from inputs except REQ-022.
REQ-016 Pop SHALL occur when req_valid_o and req_ready_i are both high; req_valid_o SHALL stay high with stable payload until popped, flushed or demand-removed.
REQ-017 dmd_hit_o[j] SHALL assert combinationally when dmd_valid_i[j] and any valid entry holds the same line address; all matching entries SHALL be invalidated at the next edge.
REQ-018 Head popped and demand-matched in the same cycle: handshake completes, dmd_hit_o asserts, entry removed once.
REQ-019 Per cycle, pops and demand removals SHALL be applied first, survivors compacted toward entry 0 preserving order, then accepted inserts appended in port order 0..INSERTS-1.
REQ-020 Free slots for inserts SHALL equal DEPTH minus occupancy plus entries freed this cycle; candidates beyond free slots SHALL be rejected (ins_accept_o=0) and drop_o SHALL pulse for one cycle.
REQ-021 Demand matching SHALL apply only to stored entries, not to same-cycle inserts.
REQ-022 flush_i SHALL have highest priority: req_valid_o and ins_accept_o forced low combinationally, all entries invalid and occupancy 0 at next edge.
REQ-023 lock_i (no flush) SHALL hold all state, force req_valid_o, ins_accept_o, dmd_hit_o and drop_o low.
REQ-024 occupancy_o SHALL never exceed DEPTH; no wrap-around or overflow of any counter.

Reset
REQ-025 While rst_ni low, all entries SHALL be invalid; req_valid_o, ins_accept_o, dmd_hit_o, drop_o SHALL be 0; occupancy_o, req_addr_o, req_tid_o SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately; first edge after deassertion SHALL accept inserts normally.

Configuration
REQ-027 With HWPF_REQ_QUEUE_DEDUP_EN defined, a candidate whose line matches a valid stored entry or a lower-numbered same-cycle candidate SHALL be discarded with ins_accept_o=0, no slot used, no drop_o.
REQ-028 Without HWPF_REQ_QUEUE_DEDUP_EN, every candidate SHALL be enqueued subject only to space, duplicates included.

Verification
REQ-029 Reset, insert 0x1040 port0 and 0x2000 port1 same cycle, ready high -> req_addr_o 0x1040 then 0x2000 on consecutive cycles, occupancy 2,1,0.
REQ-030 Fill DEPTH=8, then 2 inserts with ready low -> ins_accept_o=00, drop_o pulse 1 cycle; with ready high same cycle -> port0 accepted, port1 rejected, drop_o=1.
REQ-031 Queue holds 0x3000,0x4000,0x5000; demand 0x4010 -> dmd_hit_o=1, next cycle occupancy 2, order 0x3000,0x5000.
REQ-032 DEDUP_EN: queue holds 0x6000, insert 0x6020 port0 and 0x6030 port1 -> both rejected, drop_o=0; without macro -> both accepted, occupancy 3.
REQ-033 lock_i high 3 cycles with ready high and inserts -> no change, req_valid_o=0; flush_i with 5 entries -> occupancy 0 next cycle, req_valid_o=0.

Source files
------------

// File: rtl/hwpf_req_queue.sv
// Hardware prefetch request queue: age-ordered, compacting, with demand snoop removal.
// Entry 0 is the oldest and drives the outgoing request directly from registers.
// Optional build macro HWPF_REQ_QUEUE_DEDUP_EN discards candidates whose line is
// already queued or offered by a lower-numbered port in the same cycle.
module hwpf_req_queue #(
   parameter int unsigned LINE_BYTES = 64,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned INSERTS    = 2,
   parameter int unsigned ADDR_W     = 40,
   parameter int unsigned TID_W      = 7
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      lock_i,
   input  logic [INSERTS-1:0]        ins_valid_i,
   input  logic [INSERTS*ADDR_W-1:0] ins_addr_i,
   input  logic [INSERTS*TID_W-1:0]  ins_tid_i,
   output logic [INSERTS-1:0]        ins_accept_o,
   output logic                      drop_o,
   input  logic [INSERTS-1:0]        dmd_valid_i,
   input  logic [INSERTS*ADDR_W-1:0] dmd_addr_i,
   output logic [INSERTS-1:0]        dmd_hit_o,
   output logic                      req_valid_o,
   input  logic                      req_ready_i,
   output logic [ADDR_W-1:0]         req_addr_o,
   output logic [TID_W-1:0]          req_tid_o,
   output logic [$clog2(DEPTH):0]    occupancy_o
);

   localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
   localparam int unsigned LINE_W = ADDR_W - OFF_W;
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = IDX_W + 1;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [LINE_W-1:0] line_q [DEPTH];
   logic [LINE_W-1:0] line_d [DEPTH];
   logic [TID_W-1:0]  tid_q  [DEPTH];
   logic [TID_W-1:0]  tid_d  [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   logic [LINE_W-1:0] ins_line [INSERTS];
   logic [TID_W-1:0]  ins_tid  [INSERTS];
   logic [LINE_W-1:0] dmd_line [INSERTS];
   logic [DEPTH-1:0]  match;
   logic [INSERTS-1:0] hit_raw;
   logic [DEPTH-1:0]  kill;
   logic              active;
   logic              pop;
   logic              unused_low;

   // Slice the flattened port buses into line addresses; offset bits are ignored.
   always_comb begin
      unused_low = 1'b0;
      for (int k = 0; k < INSERTS; k++) begin
         ins_line[k] = ins_addr_i[k*ADDR_W+OFF_W +: LINE_W];
         ins_tid[k]  = ins_tid_i[k*TID_W +: TID_W];
         dmd_line[k] = dmd_addr_i[k*ADDR_W+OFF_W +: LINE_W];
         unused_low  = unused_low ^ (^ins_addr_i[k*ADDR_W +: OFF_W])
                                  ^ (^dmd_addr_i[k*ADDR_W +: OFF_W]);
      end
   end

   // Outgoing request straight from entry 0; flush/lock only gate the valid.
   always_comb begin
      active      = rst_ni & ~flush_i & ~lock_i;
      req_valid_o = valid_q[0] & ~flush_i & ~lock_i;
      req_addr_o  = {line_q[0], {OFF_W{1'b0}}};
      req_tid_o   = tid_q[0];
      occupancy_o = count_q;
      pop         = req_valid_o & req_ready_i;
   end

   // Demand snoop against stored entries only; same-cycle inserts never match.
   always_comb begin
      match   = '0;
      hit_raw = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < INSERTS; j++) begin
            if (dmd_valid_i[j] && valid_q[i] && (line_q[i] == dmd_line[j])) begin
               match[i]   = 1'b1;
               hit_raw[j] = 1'b1;
            end
         end
      end
      dmd_hit_o = lock_i ? '0 : hit_raw;
      kill      = lock_i ? '0 : match;
      kill[0]   = kill[0] | pop;
   end

   // Remove popped/snooped entries, compact survivors, then append inserts in port order.
   always_comb begin
      logic [CNT_W-1:0] cnt;
      logic             dup;
      valid_d      = '0;
      cnt          = '0;
      dup          = 1'b0;
      ins_accept_o = '0;
      drop_o       = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         line_d[i] = '0;
         tid_d[i]  = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !kill[i]) begin
            valid_d[cnt[IDX_W-1:0]] = 1'b1;
            line_d[cnt[IDX_W-1:0]]  = line_q[i];
            tid_d[cnt[IDX_W-1:0]]   = tid_q[i];
            cnt = cnt + 1'b1;
         end
      end
      for (int k = 0; k < INSERTS; k++) begin
         if (ins_valid_i[k] && active) begin
            dup = 1'b0;
`ifdef HWPF_REQ_QUEUE_DEDUP_EN
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && (line_q[i] == ins_line[k])) dup = 1'b1;
            end
            for (int m = 0; m < INSERTS; m++) begin
               if ((m < k) && ins_valid_i[m] && (ins_line[m] == ins_line[k])) dup = 1'b1;
            end
`endif
            if (!dup) begin
               if (cnt < CNT_W'(DEPTH)) begin
                  valid_d[cnt[IDX_W-1:0]] = 1'b1;
                  line_d[cnt[IDX_W-1:0]]  = ins_line[k];
                  tid_d[cnt[IDX_W-1:0]]   = ins_tid[k];
                  ins_accept_o[k]         = 1'b1;
                  cnt = cnt + 1'b1;
               end else begin
                  drop_o = 1'b1;
               end
            end
         end
      end
      count_d = cnt;
      if (lock_i) begin
         valid_d = valid_q;
         line_d  = line_q;
         tid_d   = tid_q;
         count_d = count_q;
      end
      // Flush wins over lock and everything else.
      if (flush_i) begin
         valid_d = '0;
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            line_d[i] = '0;
            tid_d[i]  = '0;
         end
      end
   end

   // Queue state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            line_q[i] <= '0;
            tid_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         line_q  <= line_d;
         tid_q   <= tid_d;
      end
   end

endmodule

// File: tb/tb_hwpf_req_queue.sv
// Directed, table-driven bench for hwpf_req_queue with default parameters.
module tb_hwpf_req_queue;

`ifdef HWPF_REQ_QUEUE_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush, lock;
   logic [1:0]  ins_valid;
   logic [79:0] ins_addr;
   logic [13:0] ins_tid;
   logic [1:0]  ins_accept;
   logic        drop;
   logic [1:0]  dmd_valid;
   logic [79:0] dmd_addr;
   logic [1:0]  dmd_hit;
   logic        req_valid, req_ready;
   logic [39:0] req_addr;
   logic [6:0]  req_tid;
   logic [3:0]  occupancy;

   int checks = 0;
   int errors = 0;

   hwpf_req_queue dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .flush_i      (flush),
      .lock_i       (lock),
      .ins_valid_i  (ins_valid),
      .ins_addr_i   (ins_addr),
      .ins_tid_i    (ins_tid),
      .ins_accept_o (ins_accept),
      .drop_o       (drop),
      .dmd_valid_i  (dmd_valid),
      .dmd_addr_i   (dmd_addr),
      .dmd_hit_o    (dmd_hit),
      .req_valid_o  (req_valid),
      .req_ready_i  (req_ready),
      .req_addr_o   (req_addr),
      .req_tid_o    (req_tid),
      .occupancy_o  (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl, lk;
      logic [1:0]  iv;
      logic [39:0] a0, a1;
      logic [6:0]  t0, t1;
      logic [1:0]  dv;
      logic [39:0] d0, d1;
      logic        rdy;
      logic [1:0]  acc;
      logic        drp;
      logic [1:0]  hit;
      logic        rv;
      logic [39:0] raddr;
      logic [6:0]  rtid;
      logic [3:0]  occ;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int unsigned fl, lk, iv, a0, a1, t0, t1, dv, d0, d1, rdy,
                               input int unsigned acc, drp, hit, rv, raddr, rtid, occ);
      vec_t v;
      v.fl = 1'(fl);   v.lk = 1'(lk);   v.iv = 2'(iv);
      v.a0 = 40'(a0);  v.a1 = 40'(a1);  v.t0 = 7'(t0);  v.t1 = 7'(t1);
      v.dv = 2'(dv);   v.d0 = 40'(d0);  v.d1 = 40'(d1); v.rdy = 1'(rdy);
      v.acc = 2'(acc); v.drp = 1'(drp); v.hit = 2'(hit); v.rv = 1'(rv);
      v.raddr = 40'(raddr); v.rtid = 7'(rtid); v.occ = 4'(occ);
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      flush     = v.fl;
      lock      = v.lk;
      ins_valid = v.iv;
      ins_addr  = {v.a1, v.a0};
      ins_tid   = {v.t1, v.t0};
      dmd_valid = v.dv;
      dmd_addr  = {v.d1, v.d0};
      req_ready = v.rdy;
   endtask

   initial begin
      int unsigned acc30, occ31;
      acc30 = DEDUP ? 0 : 3;
      occ31 = DEDUP ? 1 : 3;

      //      fl lk iv a0       a1       t0    t1    dv d0      d1      rdy| acc drp hit rv raddr   rtid  occ
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0));            // 1 idle
      vecs.push_back(mk(0,0,3,'h1040,'h2000,'h11,'h22,0,0,0,1, 3,0,0,0,0,0,0));            // 2
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                 0,0,0,1,'h1040,'h11,2));    // 3
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                 0,0,0,1,'h2000,'h22,1));    // 4
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0));            // 5
      vecs.push_back(mk(0,0,3,'h100,'h140,0,0,0,0,0,0,         3,0,0,0,0,0,0));            // 6 fill
      vecs.push_back(mk(0,0,3,'h180,'h1c0,0,0,0,0,0,0,         3,0,0,1,'h100,0,2));        // 7
      vecs.push_back(mk(0,0,3,'h200,'h240,0,0,0,0,0,0,         3,0,0,1,'h100,0,4));        // 8
      vecs.push_back(mk(0,0,3,'h280,'h2c0,0,0,0,0,0,0,         3,0,0,1,'h100,0,6));        // 9
      vecs.push_back(mk(0,0,3,'h300,'h340,0,0,0,0,0,0,         0,1,0,1,'h100,0,8));        // 10 full
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,1,'h100,0,8));        // 11
      vecs.push_back(mk(0,0,3,'h300,'h340,0,0,0,0,0,1,         1,1,0,1,'h100,0,8));        // 12
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                 0,0,0,1,'h140,0,8));        // 13
      vecs.push_back(mk(1,0,3,'h900,'h940,0,0,0,0,0,1,         0,0,0,0,0,0,7));            // 14 flush
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0));            // 15
      vecs.push_back(mk(0,0,3,'h3000,'h4000,0,0,0,0,0,0,       3,0,0,0,0,0,0));            // 16
      vecs.push_back(mk(0,0,1,'h5000,0,'h35,0,0,0,0,0,         1,0,0,1,'h3000,0,2));       // 17
      vecs.push_back(mk(0,0,0,0,0,0,0,1,'h4010,0,0,            0,0,1,1,'h3000,0,3));       // 18 snoop
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,1,'h3000,0,2));       // 19
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,                 0,0,0,1,'h3000,0,2));       // 20
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,1,'h5000,'h35,1));    // 21
      vecs.push_back(mk(0,0,0,0,0,0,0,2,0,'h5004,1,            0,0,2,1,'h5000,'h35,1));    // 22 pop+hit
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0));            // 23
      vecs.push_back(mk(0,0,1,'h7000,0,'h47,0,1,'h7000,0,0,    1,0,0,0,0,0,0));            // 24
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,1,'h7000,'h47,1));    // 25
      for (int i = 0; i < 3; i++)                                                         // 26-28
         vecs.push_back(mk(0,1,3,'ha000,'ha040,0,0,1,'h7000,0,1, 0,0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,1,'h7000,'h47,1));    // 29
      vecs.push_back(mk(0,0,3,'h7020,'h7030,0,0,0,0,0,0,       acc30,0,0,1,'h7000,'h47,1)); // 30
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,                 0,0,0,1,'h7000,'h47,occ31)); // 31

      // Reset held low with live candidates: everything must read idle.
      rst_ni = 1'b0;
      drive(mk(0,0,3,'h1000,'h1040,1,2,3,'h1000,'h1040,1, 0,0,0,0,0,0,0));
      #12;
      chk("rst_occ",   0, 64'(occupancy),  64'd0);
      chk("rst_rv",    0, 64'(req_valid),  64'd0);
      chk("rst_acc",   0, 64'(ins_accept), 64'd0);
      chk("rst_drop",  0, 64'(drop),       64'd0);
      chk("rst_hit",   0, 64'(dmd_hit),    64'd0);
      chk("rst_raddr", 0, 64'(req_addr),   64'd0);
      chk("rst_rtid",  0, 64'(req_tid),    64'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      drive(vecs[0]);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk("accept", i + 1, 64'(ins_accept), 64'(vecs[i].acc));
         chk("drop",   i + 1, 64'(drop),       64'(vecs[i].drp));
         chk("hit",    i + 1, 64'(dmd_hit),    64'(vecs[i].hit));
         chk("rvalid", i + 1, 64'(req_valid),  64'(vecs[i].rv));
         chk("occ",    i + 1, 64'(occupancy),  64'(vecs[i].occ));
         if (vecs[i].rv) begin
            chk("raddr", i + 1, 64'(req_addr), 64'(vecs[i].raddr));
            chk("rtid",  i + 1, 64'(req_tid),  64'(vecs[i].rtid));
         end
      end

      // Reset mid-operation discards entries at once; first edge after release inserts.
      @(negedge clk);
      drive(mk(0,0,3,'hb000,'hb040,5,6,0,0,0,0, 0,0,0,0,0,0,0));
      rst_ni = 1'b0;
      #1;
      chk("mrst_occ", 40, 64'(occupancy),  64'd0);
      chk("mrst_rv",  40, 64'(req_valid),  64'd0);
      chk("mrst_acc", 40, 64'(ins_accept), 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      #1;
      chk("mrst_acc_rel", 41, 64'(ins_accept), 64'd3);
      chk("mrst_occ_rel", 41, 64'(occupancy),  64'd0);
      @(negedge clk);
      ins_valid = 2'b00;
      #1;
      chk("mrst_occ_after", 42, 64'(occupancy), 64'd2);
      chk("mrst_raddr",     42, 64'(req_addr),  64'h0b000);
      chk("mrst_rtid",      42, 64'(req_tid),   64'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
